// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serial frame transmitter for driving the single-bit input of the Moore
// sequence detectors. Each accepted payload becomes one frame on dout:
// the sync pattern MSB first, then the payload MSB first, then GAP idle zeros.
//
// Ports
//   clk        : clock, rising-edge active
//   reset      : asynchronous, active-high reset
//   start      : payload valid; accepted on an edge where start && ready
//   data_in    : payload word, sampled only at the accept edge
//   ready      : high only while idle (a frame can be accepted)
//   dout       : registered serial output bit
//   frame_done : one-cycle pulse in the first idle-gap cycle of a frame
//   frame_cnt  : number of completed frames, wraps 255 -> 0
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int               DATA_W  = 8,
  parameter int               GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              dout,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  localparam int MAX_A = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int MAX_N = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam int SR_W  = PAT_W + DATA_W;

  localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // Sync pattern and payload share one shift register so SYNC and DATA both
  // simply emit the MSB and shift left; no per-bit index mux is needed.
  logic [SR_W-1:0]   sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sr         <= '0;
      ready      <= 1'b1;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          dout <= 1'b0;
          if (start) begin
            // The first sync bit goes out directly; the register holds the
            // remaining bits already shifted by one.
            state <= S_SYNC;
            cnt   <= '0;
            sr    <= {PATTERN, data_in} << 1;
            dout  <= PATTERN[PAT_W-1];
            ready <= 1'b0;
          end
        end
        S_SYNC: begin
          // On the last sync cycle the MSB is already payload bit D[DATA_W-1].
          dout <= sr[SR_W-1];
          sr   <= sr << 1;
          if (cnt == PAT_LAST) begin
            state <= S_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == DATA_LAST) begin
            state      <= S_GAP;
            cnt        <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end else begin
            dout <= sr[SR_W-1];
            sr   <= sr << 1;
            cnt  <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          dout <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          ready <= 1'b1;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the single-bit `din` input of the team's Moore sequence detectors. It accepts a parallel payload word through a valid/ready handshake and emits a framed bit stream on `dout`, one bit per clock: a fixed sync pattern (default 1001), the payload MSB first, then a run of idle zeros. It is the stimulus and link-side companion to the detector blocks, and lets benches and top levels produce detector-valid streams without hand-written bit sequences.

## Interface
- `PAT_W`, 4: sync pattern width in bits (1..16)
- `PATTERN`, 4'b1001: sync pattern, sent MSB first
- `DATA_W`, 8: payload width in bits (1..32)
- `GAP`, 2: idle zero cycles after each frame (1..15)
- `clk`  input  1  clock, rising-edge active
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  payload valid; frame accepted on a rising edge where `start && ready`
- `data_in`  input  DATA_W  payload, sampled only at the accept edge
- `ready`  output  1  high only in IDLE; block can accept a frame
- `dout`  output  1  serial output bit, registered (Moore)
- `frame_done`  output  1  one-cycle pulse marking the end of a frame's last payload bit
- `frame_cnt`  output  8  count of completed frames, wraps 255 -> 0

## Operation
- States:
  - IDLE: `dout`=0, `ready`=1.
  - SYNC: PAT_W cycles, sends `PATTERN[PAT_W-1]` down to `PATTERN[0]`.
  - DATA: DATA_W cycles, sends `data_in[DATA_W-1]` down to `data_in[0]`.
  - GAP: GAP cycles, `dout`=0.
- Transitions:
  - IDLE -> SYNC on accept.
  - SYNC -> DATA after its last sync bit.
  - DATA -> GAP after its last payload bit.
  - GAP -> IDLE after GAP cycles.
- Payload is latched into a shift register at the accept edge. Later changes on `data_in` have no effect.
- `start` is ignored outside IDLE. No queueing.
- A single bit counter, sized to hold max(PAT_W, DATA_W, GAP), is reused by each state and cleared on every state change.
- `dout` is a flop output. It is a pure function of registered state and contains no combinational path from `start` or `data_in`.
- `frame_done` and the `frame_cnt` increment happen together, on the edge that moves DATA -> GAP.
- Payload content is not stuffed. A payload containing the sync pattern can produce extra detector hits, and this is accepted behaviour.
- Reset (asynchronous, any state):
  - State forced to IDLE.
  - `dout`=0, `ready`=1, `frame_done`=0, `frame_cnt`=0.
  - Shift register and bit counter cleared.
  - An in-flight frame is aborted without `frame_done`.

## Timing
- Accept edge E0. With defaults, `dout` holds:
  - after E0 .. E0+3: sync bits 1,0,0,1
  - after E0+4 .. E0+11: D7..D0
  - after E0+12, E0+13: zeros
  - after E0+14: IDLE, `ready`=1
- General case: first sync bit one cycle after E0. Frame occupies PAT_W+DATA_W+GAP cycles. `ready` returns PAT_W+DATA_W+GAP cycles after E0.
- `frame_done` is high for the single cycle after edge E0+PAT_W+DATA_W, which is the first GAP cycle.
- Back-to-back with `start` held high: the next accept is on the first edge where `ready`=1. Minimum frame period is PAT_W+DATA_W+GAP+1 cycles (15 with defaults). The single IDLE cycle drives `dout`=0.
- `ready` is low from the cycle after E0 until IDLE is re-entered.
- Reset asserted mid-frame: `dout` goes to 0 asynchronously without waiting for a clock edge. After release, the first accept is possible on the next rising edge.

## Test plan
- Single frame with defaults, `data_in`=8'hA5 accepted at E0 -> `dout` after E0..E0+13 = 1,0,0,1,1,0,1,0,0,1,0,1,0,0. `frame_done` high only in the cycle after E0+12. `frame_cnt`=1. `ready` high again after E0+14.
- Back-to-back, `start` held high, payloads 8'h00 then 8'hFF -> second sync begins 15 cycles after the first. Exactly one `dout`=0 IDLE cycle separates the frames. `frame_cnt`=2. Feeding `dout` into the 1001 non-overlapping Moore detector gives one hit per frame.
- `start` pulsed and `data_in` changed during SYNC/DATA -> no new frame and no change to the transmitted payload. `ready` stays 0 until IDLE.
- Reset asserted during payload bit D3 of a frame -> `dout`=0 immediately, `frame_cnt`=0, no `frame_done`. A new frame of 8'h3C sent after release is bit-exact.
- 256 frames sent -> `frame_cnt` wraps 255 -> 0 on the 256th `frame_done`.
- Parameter variant PAT_W=3, PATTERN=3'b110, DATA_W=4, GAP=1, `data_in`=4'b1001 -> `dout` = 1,1,0,1,0,0,1,0. Frame period is 9 cycles.
